// File: rtl/timer_reload_scheduler.sv
// Round-robin reload scheduler: per-timer expiry pulses become pending requests, granted one per transfer.
// Optional starvation monitor enabled by defining TRS_STARVE_MON_EN.
module timer_reload_scheduler #(
  parameter int TIMER_NUM = 5,
  parameter int VAL_W = 10,
  parameter logic [VAL_W-1:0] RST_LOAD = VAL_W'(10'h3FF),
  localparam int IDX_W = (TIMER_NUM > 1) ? $clog2(TIMER_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TIMER_NUM-1:0] time_out,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [VAL_W-1:0]     cfg_data,
  input  logic [TIMER_NUM-1:0] auto_en,
  input  logic                 ovf_clr,
  output logic                 load_valid,
  input  logic                 load_ready,
  output logic [IDX_W-1:0]     load_idx,
  output logic [VAL_W-1:0]     load_value,
  output logic [TIMER_NUM-1:0] load_en,
  output logic [TIMER_NUM-1:0] pending,
`ifdef TRS_STARVE_MON_EN
  output logic [TIMER_NUM-1:0] starve_flag,
`endif
  output logic [TIMER_NUM-1:0] overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_found;
  logic                 transfer;
  logic                 do_grant;
  logic [TIMER_NUM-1:0] capture;
  logic [TIMER_NUM-1:0] grant_vec;
  logic [TIMER_NUM-1:0] ovf_set;
  logic [VAL_W-1:0]     reload_regs [TIMER_NUM];

  assign transfer = load_valid & load_ready;
  assign capture  = time_out & auto_en;
  assign do_grant = arb_found && ((state == IDLE) || transfer);
  assign ovf_set  = capture & pending & ~grant_vec;

  // First pending timer after the last grant, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr;
    for (int k = 1; k <= TIMER_NUM; k++) begin
      int cand;
      cand = (int'(rr) + k) % TIMER_NUM;
      if (!arb_found && pending[cand]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (do_grant) grant_vec[arb_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= IDX_W'(TIMER_NUM - 1);
      pending    <= '0;
      overflow   <= '0;
      load_valid <= 1'b0;
      load_idx   <= '0;
      load_value <= '0;
      load_en    <= '0;
      for (int i = 0; i < TIMER_NUM; i++) reload_regs[i] <= RST_LOAD;
    end else begin
      // A request granted on this edge frees its slot for a simultaneous new pulse.
      pending  <= (pending & ~grant_vec) | capture;
      overflow <= (overflow & ~{TIMER_NUM{ovf_clr}}) | ovf_set;
      if (cfg_we && (int'(cfg_idx) < TIMER_NUM)) reload_regs[cfg_idx] <= cfg_data;

      case (state)
        IDLE: begin
          if (do_grant) begin
            load_valid <= 1'b1;
            load_idx   <= arb_idx;
            load_value <= reload_regs[arb_idx];
            load_en    <= grant_vec;
            rr         <= arb_idx;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (do_grant) begin
            load_idx   <= arb_idx;
            load_value <= reload_regs[arb_idx];
            load_en    <= grant_vec;
            rr         <= arb_idx;
          end else if (transfer) begin
            load_valid <= 1'b0;
            load_en    <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRS_STARVE_MON_EN
  logic [7:0] wait_cnt [TIMER_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_flag <= '0;
      for (int i = 0; i < TIMER_NUM; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < TIMER_NUM; i++) begin
        if (grant_vec[i]) wait_cnt[i] <= '0;
        else if (pending[i] && (wait_cnt[i] != 8'hFF)) wait_cnt[i] <= wait_cnt[i] + 8'd1;
        starve_flag[i] <= (starve_flag[i] & ~ovf_clr) | (wait_cnt[i] == 8'hFF);
      end
    end
  end
`endif

endmodule
